// File: rtl/uart_rx_checker.sv
// UART frame checker: flags parity/start/stop/break errors on each deserialised frame,
// buffers one checked frame, tracks sticky status and saturating error counters.
module uart_rx_checker #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           parity_type,
  input  logic                 frame_valid,
  input  logic [DATA_W-1:0]    frame_data,
  input  logic                 frame_start,
  input  logic                 frame_parity,
  input  logic [STOP_BITS-1:0] frame_stop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [3:0]           out_err,
  output logic [4:0]           status,
  input  logic                 status_clr,
  input  logic [1:0]           cnt_sel,
  output logic [CNT_W-1:0]     err_cnt,
  input  logic                 cnt_clr
);

  localparam logic [1:0]       PAR_ODD  = 2'b01;
  localparam logic [1:0]       PAR_EVEN = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             parity_en;
  logic             parity_err;
  logic             start_err;
  logic             stop_err;
  logic             break_det;
  logic [3:0]       frame_err;
  logic             accept;
  logic             overrun;
  logic [3:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [4];

  always_comb begin
    parity_en  = (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
    parity_err = 1'b0;
    if (parity_type == PAR_ODD)
      parity_err = ((^frame_data) == frame_parity);
    else if (parity_type == PAR_EVEN)
      parity_err = ((^frame_data) != frame_parity);
    start_err = frame_start;
    // Break is an all-zero line; the parity bit only counts when it exists.
    break_det = !frame_start && (frame_data == '0) && (frame_stop == '0)
                && (!parity_en || !frame_parity);
    stop_err  = !(&frame_stop) || break_det;
    frame_err = {break_det, stop_err, start_err, parity_err};
  end

  assign accept  = frame_valid && (!out_valid || out_ready);
  assign overrun = frame_valid && out_valid && !out_ready;
  assign cnt_inc = {overrun, accept & stop_err, accept & start_err, accept & parity_err};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= frame_data;
      out_err   <= frame_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A flag raised in the same cycle as status_clr survives the clear.
  always_ff @(posedge clk) begin
    if (!reset_n)
      status <= '0;
    else
      status <= (status_clr ? 5'b0 : status)
                | {overrun, (accept ? frame_err : 4'b0)};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset_n || cnt_clr)
        cnt_q[i] <= '0;
      else if (cnt_inc[i] && (cnt_q[i] != CNT_MAX))
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  always_comb begin
    err_cnt = cnt_q[0];
    case (cnt_sel)
      2'd1:    err_cnt = cnt_q[1];
      2'd2:    err_cnt = cnt_q[2];
      2'd3:    err_cnt = cnt_q[3];
      default: err_cnt = cnt_q[0];
    endcase
  end

endmodule
